onecount_sched: RTL and testbench

// - Shared ones-count engine for NREQ requesters: round-robin arbitration, iterative popcount of a DW-bit word.
// - Processes CHUNK bits per cycle and returns the count with the requester ID over a valid/ready result port.
// - Replaces per-client combinational onecount instances wherever DW-bit population counts are needed at low rate.

---
 rtl/onecount_sched.sv | 149 ++++++++++++++
 tb/tb_onecount_sched.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/onecount_sched.sv
// Shared round-robin ones-count engine: grants one requester, counts CHUNK bits per cycle, returns count + ID.
// Build option ONECOUNT_ZERO_SKIP_EN: finish counting early once the unshifted remainder is all zero.
module onecount_sched #(
  parameter int NREQ  = 4,
  parameter int DW    = 16,
  parameter int CHUNK = 4,
  parameter int CW    = 5,
  parameter int IDW   = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NREQ-1:0]      REQ_VALID,
  input  logic [NREQ*DW-1:0]   REQ_DATA,
  output logic [NREQ-1:0]      REQ_READY,
  output logic                 RES_VALID,
  input  logic                 RES_READY,
  output logic [CW-1:0]        RES_COUNT,
  output logic [IDW-1:0]       RES_ID,
  output logic                 BUSY
);

  localparam int NCHUNK = DW / CHUNK;
  localparam int CTRW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CTRW-1:0] CTR_LAST = CTRW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [DW-1:0]   shift_q, shift_d;
  logic [CW-1:0]   acc_q, acc_d;
  logic [CTRW-1:0] ctr_q, ctr_d;
  logic [IDW-1:0]  id_q, id_d;

  logic            found;
  int              gnt_idx;
  logic [NREQ-1:0] grant_oh;
  logic [DW-1:0]   sel_data;

  function automatic logic [CW-1:0] chunk_ones(input logic [CHUNK-1:0] c);
    logic [CW-1:0] sum;
    sum = '0;
    for (int i = 0; i < CHUNK; i++) begin
      sum = sum + CW'(c[i]);
    end
    return sum;
  endfunction

  // Round-robin search starting at the pointer; the first valid requester wins.
  always_comb begin
    found   = 1'b0;
    gnt_idx = 0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (int'(ptr_q) + k) % NREQ;
      if (!found && REQ_VALID[idx]) begin
        found   = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      grant_oh[i] = found && (gnt_idx == i);
      if (gnt_idx == i) begin
        sel_data = REQ_DATA[i*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    shift_d   = shift_q;
    acc_d     = acc_q;
    ctr_d     = ctr_q;
    id_d      = id_q;
    REQ_READY = '0;
    case (state_q)
      IDLE: begin
        REQ_READY = grant_oh;
        if (found) begin
          shift_d = sel_data;
          acc_d   = '0;
          ctr_d   = '0;
          id_d    = IDW'(gnt_idx);
          ptr_d   = (gnt_idx == NREQ - 1) ? '0 : IDW'(gnt_idx + 1);
          state_d = COUNT;
        end
      end
      COUNT: begin
        acc_d   = acc_q + chunk_ones(shift_q[CHUNK-1:0]);
        shift_d = shift_q >> CHUNK;
        ctr_d   = ctr_q + CTRW'(1);
        if (ctr_q == CTR_LAST) begin
          state_d = DONE;
        end
`ifdef ONECOUNT_ZERO_SKIP_EN
        // Nothing left to count once the remainder is zero, so acc_d is already final.
        if (shift_d == '0) begin
          state_d = DONE;
        end
`endif
      end
      DONE: begin
        if (RES_READY) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and result registers are reset; the shift register only holds sampled data.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      acc_q   <= '0;
      ctr_q   <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      acc_q   <= acc_d;
      ctr_q   <= ctr_d;
      id_q    <= id_d;
    end
  end

  always_ff @(posedge CLK) begin
    shift_q <= shift_d;
  end

  assign RES_VALID = (state_q == DONE);
  assign RES_COUNT = acc_q;
  assign RES_ID    = id_q;
  assign BUSY      = (state_q != IDLE);

endmodule

// File: tb/tb_onecount_sched.sv
// Directed bench for onecount_sched with a transaction-level reference model checked every cycle.
module tb_onecount_sched;

  localparam int NREQ   = 4;
  localparam int DW     = 16;
  localparam int CHUNK  = 4;
  localparam int CW     = 5;
  localparam int IDW    = 2;
  localparam int NCHUNK = DW / CHUNK;

  logic                 clk;
  logic                 RST;
  logic [NREQ-1:0]      REQ_VALID;
  logic [NREQ*DW-1:0]   REQ_DATA;
  logic [NREQ-1:0]      REQ_READY;
  logic                 RES_VALID;
  logic                 RES_READY;
  logic [CW-1:0]        RES_COUNT;
  logic [IDW-1:0]       RES_ID;
  logic                 BUSY;

  int total = 0;
  int bad   = 0;

  onecount_sched #(
    .NREQ(NREQ), .DW(DW), .CHUNK(CHUNK), .CW(CW), .IDW(IDW)
  ) dut (
    .CLK(clk),
    .RST(RST),
    .REQ_VALID(REQ_VALID),
    .REQ_DATA(REQ_DATA),
    .REQ_READY(REQ_READY),
    .RES_VALID(RES_VALID),
    .RES_READY(RES_READY),
    .RES_COUNT(RES_COUNT),
    .RES_ID(RES_ID),
    .BUSY(BUSY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Edges from handshake to result: full word, or up to the highest non-zero chunk when skipping.
  function automatic int word_latency(input logic [DW-1:0] d);
    int lat;
`ifdef ONECOUNT_ZERO_SKIP_EN
    logic [DW-1:0] t;
    lat = 1;
    for (int i = 0; i < NCHUNK; i++) begin
      t = d >> (i * CHUNK);
      if (t[CHUNK-1:0] != '0) lat = i + 1;
    end
`else
    lat = NCHUNK;
`endif
    return lat;
  endfunction

  function automatic logic [NREQ-1:0] rr_pick(input int ptr, input logic [NREQ-1:0] v);
    logic [NREQ-1:0] oh;
    oh = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (oh == '0 && v[(ptr + k) % NREQ]) oh[(ptr + k) % NREQ] = 1'b1;
    end
    return oh;
  endfunction

  // Reference model: phase 0 = free, 1 = word in flight, 2 = result offered.
  int              m_phase = 0;
  int              m_ptr   = 0;
  int              m_left  = 0;
  int              m_cnt   = 0;
  int              m_id    = 0;
  bit              m_on    = 0;
  logic [NREQ-1:0] m_rdy;

  always @(negedge clk) begin
    m_rdy = (m_phase == 0) ? rr_pick(m_ptr, REQ_VALID) : '0;
    if (m_on) begin
      check("req_ready", 32'(REQ_READY), 32'(m_rdy));
      check("busy", 32'(BUSY), 32'(m_phase != 0));
      check("res_valid", 32'(RES_VALID), 32'(m_phase == 2));
      if (m_phase == 2) begin
        check("res_count", 32'(RES_COUNT), 32'(m_cnt));
        check("res_id", 32'(RES_ID), 32'(m_id));
      end
    end
    if (RST) begin
      m_phase = 0;
      m_ptr   = 0;
      m_on    = 1;
    end else if (m_on) begin
      case (m_phase)
        0: if (m_rdy != '0) begin
          for (int i = 0; i < NREQ; i++) begin
            if (m_rdy[i]) begin
              m_id   = i;
              m_cnt  = $countones(REQ_DATA[i*DW +: DW]);
              m_left = word_latency(REQ_DATA[i*DW +: DW]);
            end
          end
          m_ptr   = (m_id + 1) % NREQ;
          m_phase = 1;
        end
        1: begin
          m_left--;
          if (m_left == 0) m_phase = 2;
        end
        default: if (RES_READY) m_phase = 0;
      endcase
    end
  end

  task automatic wait_valid(output int edges);
    bit got;
    got   = 0;
    edges = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (RES_VALID === 1'b1) got = 1;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL res_timeout: got no RES_VALID after %0d edges, expected one", edges);
    end
  endtask

  // Enters and leaves just after a rising edge with the engine free.
  task automatic run_single(input logic [DW-1:0] data, input int exp_cnt, input int exp_lat);
    int lat;
    REQ_VALID = 4'b0001;
    REQ_DATA[DW-1:0] = data;
    @(negedge clk);
    check("single_grant", 32'(REQ_READY), 32'h1);
    @(posedge clk); #1;
    REQ_VALID = '0;
    wait_valid(lat);
    check("single_latency", 32'(lat), 32'(exp_lat));
    check("single_count", 32'(RES_COUNT), 32'(exp_cnt));
    check("single_id", 32'(RES_ID), 32'h0);
    @(posedge clk); #1;
  endtask

  logic [DW-1:0] words [5] = '{16'h0000, 16'h0001, 16'h0100, 16'h7FFF, 16'hFFFF};
  int            cnts  [5] = '{0, 1, 1, 15, 16};
`ifdef ONECOUNT_ZERO_SKIP_EN
  int            lats  [5] = '{1, 1, 3, 4, 4};
`else
  int            lats  [5] = '{4, 4, 4, 4, 4};
`endif
  int            rr_ids [5] = '{0, 1, 2, 3, 0};

  initial begin
    int lat;
    RST       = 1'b1;
    REQ_VALID = '0;
    REQ_DATA  = '0;
    RES_READY = 1'b1;
    repeat (2) @(posedge clk);
    #1 RST = 1'b0;
    @(negedge clk);
    check("rst_res_valid", 32'(RES_VALID), 32'h0);
    check("rst_res_count", 32'(RES_COUNT), 32'h0);
    check("rst_res_id", 32'(RES_ID), 32'h0);
    check("rst_busy", 32'(BUSY), 32'h0);
    @(posedge clk); #1;

    run_single(16'h5555, 8, 4);
    for (int i = 0; i < 5; i++) run_single(words[i], cnts[i], lats[i]);

    // Round robin from a fresh pointer.
    RST = 1'b1;
    @(posedge clk); #1;
    RST = 1'b0;
    REQ_VALID = 4'b1111;
    REQ_DATA  = {16'h000F, 16'h0007, 16'h0003, 16'h0001};
    for (int n = 0; n < 5; n++) begin
      wait_valid(lat);
      check("rr_id", 32'(RES_ID), 32'(rr_ids[n]));
      check("rr_count", 32'(RES_COUNT), 32'(rr_ids[n] + 1));
      @(posedge clk); #1;
    end
    REQ_VALID = '0;

    // Consumer stall with a competing request held.
    REQ_VALID = 4'b0100;
    REQ_DATA[2*DW +: DW] = 16'h0F0F;
    RES_READY = 1'b0;
    wait_valid(lat);
    for (int n = 0; n < 5; n++) begin
      check("stall_valid", 32'(RES_VALID), 32'h1);
      check("stall_count", 32'(RES_COUNT), 32'd8);
      check("stall_id", 32'(RES_ID), 32'd2);
      check("stall_ready", 32'(REQ_READY), 32'h0);
      check("stall_busy", 32'(BUSY), 32'h1);
      @(negedge clk);
    end
    @(posedge clk); #1;
    RES_READY = 1'b1;
    REQ_VALID = '0;
    @(posedge clk); #1;

    // Reset in the middle of counting a full word.
    REQ_VALID = 4'b0001;
    REQ_DATA[DW-1:0] = 16'hFFFF;
    @(posedge clk); #1;
    REQ_VALID = 4'b0100;
    REQ_DATA[2*DW +: DW] = 16'h00FF;
    @(posedge clk); #1;
    RST = 1'b1;
    @(posedge clk); #1;
    RST = 1'b0;
    @(negedge clk);
    check("abort_res_valid", 32'(RES_VALID), 32'h0);
    check("abort_busy", 32'(BUSY), 32'h0);
    check("abort_grant", 32'(REQ_READY), 32'h4);
    check("abort_res_id", 32'(RES_ID), 32'h0);
    @(posedge clk); #1;
    REQ_VALID = '0;
    wait_valid(lat);
    check("abort_next_id", 32'(RES_ID), 32'd2);
    check("abort_next_count", 32'(RES_COUNT), 32'd8);
    @(posedge clk); #1;

    // Requester 1 appears only while the engine is busy.
    REQ_VALID = 4'b0001;
    REQ_DATA[DW-1:0] = 16'h1234;
    @(posedge clk); #1;
    REQ_VALID = 4'b0010;
    @(posedge clk); #1;
    @(posedge clk); #1;
    REQ_VALID = '0;
    wait_valid(lat);
    check("drop_id", 32'(RES_ID), 32'd0);
    check("drop_count", 32'(RES_COUNT), 32'd5);
    repeat (4) @(posedge clk);
    #1;
    check("drop_idle_busy", 32'(BUSY), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
